// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// one-cycle valid / framing-error strobes.
module uart_rx #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    input  logic       rx_in,
    output logic [7:0] rx_out,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    // state     | meaning
    // WAIT_HIGH | line must be seen high before a start can be accepted
    // IDLE      | armed, waiting for a falling edge on the synchronised line
    // START     | counting to the middle of the start bit to confirm it
    // DATA      | sampling 8 data bits, LSB first, at each bit centre
    // STOP      | sampling the stop bit, then strobe valid or framing error
    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SETTLE = CW'(2);

    state_t        state;
    logic          s_meta;
    logic          s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state        <= WAIT_HIGH;
            s_meta       <= 1'b1;
            s            <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_out       <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            s_meta       <= rx_in;
            s            <= s_meta;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;

            case (state)
                // The synchroniser leaves reset holding ones, so demand three
                // consecutive highs; otherwise a line stuck low at reset release
                // would look idle for two cycles and cause a false start.
                WAIT_HIGH: begin
                    if (!s) begin
                        cnt <= '0;
                    end else if (cnt == SETTLE) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!s) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Re-arming right at the stop sample point lets a following
                // start bit be caught with no idle gap between frames.
                STOP: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        rx_busy <= 1'b0;
                        if (s) begin
                            rx_out   <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state   <= WAIT_HIGH;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: framed bytes from a bit-level
// transmitter model, glitch, framing error, mid-frame reset and baud skew.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int NV   = 8;

    logic       rx_clk = 1'b0;
    logic       rx_rst;
    logic       rx_in;
    logic [7:0] rx_out;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .rx_clk       (rx_clk),
        .rx_rst       (rx_rst),
        .rx_in        (rx_in),
        .rx_out       (rx_out),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 rx_clk = ~rx_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_n = 0;
    int start_cyc = 0;

    int valid_cnt = 0;
    int err_cnt = 0;
    int busy_cycles = 0;
    int overlap_cnt = 0;
    int double_cnt = 0;
    bit prev_pulse = 1'b0;
    logic [7:0] got_q[$];
    int         got_cyc[$];

    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin
        if (rx_valid) begin
            valid_cnt++;
            got_q.push_back(rx_out);
            got_cyc.push_back(cyc);
        end
        if (rx_frame_err) err_cnt++;
        if (rx_busy) busy_cycles++;
        if (rx_valid && rx_frame_err) overlap_cnt++;
        if ((rx_valid || rx_frame_err) && prev_pulse) double_cnt++;
        prev_pulse = rx_valid || rx_frame_err;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    // One bit period; with stretch, every 33rd transmitter cycle lasts two clocks.
    task automatic hold_bit(input logic b, input bit stretch);
        rx_in = b;
        for (int k = 0; k < CPB; k++) begin
            @(posedge rx_clk);
            #1;
            tx_n++;
            if (stretch && (tx_n % 33 == 0)) begin
                @(posedge rx_clk);
                #1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit stretch);
        start_cyc = cyc;
        hold_bit(1'b0, stretch);
        for (int b = 0; b < 8; b++) hold_bit(data[b], stretch);
        hold_bit(stop_bit, stretch);
    endtask

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[NV];
    logic [7:0] rnd[20];
    logic [7:0] g;
    int v0, e0, start0;

    initial begin
        vecs[0] = '{8'hA5, 20, 8'hA5};
        vecs[1] = '{8'h00,  0, 8'h00};
        vecs[2] = '{8'hFF,  0, 8'hFF};
        vecs[3] = '{8'h3C, 30, 8'h3C};
        vecs[4] = '{8'h01,  5, 8'h01};
        vecs[5] = '{8'h80,  0, 8'h80};
        vecs[6] = '{8'h55,  3, 8'h55};
        vecs[7] = '{8'hAA, 10, 8'hAA};

        rx_rst = 1'b1;
        rx_in  = 1'b1;
        @(posedge rx_clk);
        #1;
        check("reset_rx_out", rx_out, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_frame_err", rx_frame_err, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        idle(2);
        rx_rst = 1'b0;
        idle(10);

        // Table: matched frames, including back-to-back with no idle gap
        got_q.delete();
        got_cyc.delete();
        e0 = err_cnt;
        start0 = 0;
        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].data, 1'b1, 1'b0);
            if (i == 0) start0 = start_cyc;
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        idle(3 * CPB);
        check("table_count", got_q.size(), NV);
        for (int i = 0; i < NV; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("table_byte_%0d", i), g, vecs[i].exp_byte);
        end
        if (got_cyc.size() > 0)
            check_range("latency_A5", got_cyc[0] - start0, 3 + HALF + 9 * CPB - 1, 3 + HALF + 9 * CPB + 1);
        else
            check("latency_A5_present", got_cyc.size(), 1);
        check("table_frame_err", err_cnt - e0, 0);

        // Glitch shorter than half a bit
        v0 = valid_cnt;
        e0 = err_cnt;
        busy_cycles = 0;
        rx_in = 1'b0;
        idle(5);
        rx_in = 1'b1;
        idle(40);
        check_range("glitch_busy_cycles", busy_cycles, 1, HALF + 3);
        check("glitch_busy_now", rx_busy, 1'b0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_err", err_cnt - e0, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(20);
        check("after_glitch_byte", rx_out, 8'h5A);
        check("after_glitch_valid", valid_cnt - v0, 1);

        // Framing error followed by a held-low line
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        check("ferr_pulse", err_cnt - e0, 1);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_rx_out_kept", rx_out, 8'h5A);
        busy_cycles = 0;
        idle(40);
        rx_in = 1'b1;
        idle(20);
        check("ferr_hold_no_busy", busy_cycles, 0);
        check("ferr_hold_no_err", err_cnt - e0, 1);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(20);
        check("after_ferr_byte", rx_out, 8'h7E);
        check("after_ferr_valid", valid_cnt - v0, 1);

        // Reset during data bit 4 of 8'hC3 (bits LSB first: 1,1,0,0,0,0,1,1)
        v0 = valid_cnt;
        e0 = err_cnt;
        hold_bit(1'b0, 1'b0);
        hold_bit(1'b1, 1'b0);
        hold_bit(1'b1, 1'b0);
        hold_bit(1'b0, 1'b0);
        hold_bit(1'b0, 1'b0);
        rx_in = 1'b0;
        idle(6);
        rx_rst = 1'b1;
        idle(1);
        check("midrst_rx_out", rx_out, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_rx_frame_err", rx_frame_err, 1'b0);
        check("midrst_rx_busy", rx_busy, 1'b0);
        rx_rst = 1'b0;
        idle(9);
        hold_bit(1'b0, 1'b0);
        hold_bit(1'b1, 1'b0);
        hold_bit(1'b1, 1'b0);
        hold_bit(1'b1, 1'b0);
        idle(3 * CPB);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(20);
        check("after_rst_byte", rx_out, 8'h42);
        check("after_rst_valid", valid_cnt - v0, 1);

        // Transmitter about 3% slow
        got_q.delete();
        e0 = err_cnt;
        tx_n = 0;
        for (int i = 0; i < 20; i++) rnd[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 20; i++) begin
            send_frame(rnd[i], 1'b1, 1'b1);
            idle(2);
        end
        idle(3 * CPB);
        check("slow_count", got_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("slow_byte_%0d", i), g, rnd[i]);
        end
        check("slow_frame_err", err_cnt - e0, 0);

        check("pulse_overlap", overlap_cnt, 0);
        check("pulse_consecutive", double_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: 8N1 framing, LSB first, one start bit, one stop bit.
- Consumes the line driven by uart_tx and recovers each byte, presenting it as a parallel byte with a one-cycle valid strobe.
- Sits at the device boundary. rx_in is asynchronous to rx_clk and is synchronised internally.
- Uses the same CLKS_PER_BIT timing convention as the transmitter, so a matched pair interoperates.

Parameters:
- CLKS_PER_BIT, default 521, rx_clk cycles per bit: f(rx_clk)/baud, e.g. 10 MHz / 19200.
  - Legal range 4..65535.
  - Internal bit counter width is $clog2(CLKS_PER_BIT); it must never truncate.

Ports:
- rx_clk  in  1  receiver clock; all logic on posedge.
- rx_rst  in  1  synchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idle high.
- rx_out  out  8  last correctly framed byte; holds its value until the next good byte.
- rx_valid  out  1  one-cycle pulse; rx_out is updated in the same cycle.
- rx_frame_err  out  1  one-cycle pulse; stop bit sampled low, byte discarded.
- rx_busy  out  1  high while in START, DATA or STOP.

Behaviour:
- Clocking and reset:
  - One clock, rx_clk. Reset is synchronous and active-high on rx_rst.
  - In reset: rx_out=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, both synchroniser flops=1, counter=0, bit index=0, state=WAIT_HIGH.
- Synchroniser: two-flop synchroniser on rx_in gives s. The FSM uses only s, so s lags rx_in by 2 cycles.
- Constant HALF = (CLKS_PER_BIT-1)/2, integer division.
- WAIT_HIGH: stay until s==1, then go to IDLE.
  - Purpose: prevents false starts after reset, or after a break or framing error.
- IDLE: counter=0, bit index=0. On s==0, go to START.
- START:
  - Counter increments each cycle.
  - When counter==HALF: if s==0, counter=0 and go to DATA. If s==1, the start was a glitch: go to IDLE with no pulse.
- DATA:
  - When counter==CLKS_PER_BIT-1: shift[bit index] <= s, counter=0, bit index++. Otherwise counter++.
  - After bit index 7 is sampled, go to STOP.
  - Sample point is the mid-bit of each data bit.
- STOP: when counter==CLKS_PER_BIT-1, sample s:
  - s==1: rx_out<=shift, rx_valid=1 for one cycle, go to IDLE.
    - Re-arming at mid-stop allows back-to-back frames with no idle gap.
  - s==0: rx_frame_err=1 for one cycle, rx_out unchanged, go to WAIT_HIGH.
- Pulse exclusivity: rx_valid and rx_frame_err are never high together, and are never high for two consecutive cycles.
- Latency: rx_valid rises 3+HALF+9*CLKS_PER_BIT cycles (±1) after the rx_in falling edge that started the frame.
- rx_busy is a registered decode of state (high in START, DATA, STOP).
- Reset mid-frame: rx_rst has priority over all state logic. The partial byte is dropped with no pulse.
  - A frame already in progress on the line after reset is ignored until the line returns high.
- Line held low indefinitely (break): exactly one rx_frame_err, then no further activity until s==1.
- Baud mismatch tolerance: the design must receive correctly with the transmitter's CLKS_PER_BIT within ±3% of the receiver's.

Test Plan:
1. CLKS_PER_BIT=16. Drive frame 8'hA5 from a matched uart_tx model, idle high beforehand.
   -> rx_out=8'hA5, single rx_valid pulse at 3+7+144=154 ±1 cycles after the start edge, rx_frame_err never high.
2. Back-to-back frames 8'h00, 8'hFF, 8'h3C with zero idle between stop and next start.
   -> three rx_valid pulses, rx_out sequence 00, FF, 3C, no errors.
3. Glitch: rx_in low for 5 cycles (< HALF), then high.
   -> no pulses; rx_busy high for at most HALF+3 cycles, then back in IDLE.
   Then a valid frame 8'h5A -> rx_out=8'h5A.
4. Framing error: frame 8'h81 with stop bit forced low, line held low 40 cycles, then high, then frame 8'h7E.
   -> one rx_frame_err pulse; rx_out keeps its prior value (not 81); no start is detected during the low hold; then rx_valid with 8'h7E.
5. Reset mid-frame: assert rx_rst for 1 cycle during data bit 4 of 8'hC3, line still carrying the frame.
   -> outputs at reset values next cycle, no pulses for that frame; the following frame 8'h42 is received correctly.
6. Tolerance: transmitter at CLKS_PER_BIT=16 with every 33rd cycle stretched (≈3% slow), 20 random bytes.
   -> all 20 bytes received with matching values, zero frame errors.
